instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped instruction cache between the CPU PC output and the instruction memory.
//  - Supplies the 32-bit INSTRUCTION word to the cpu.
//  - On a miss, fetches a 16-byte block from instruction memory.
//  - Holds BUSY_WAIT high until the instruction is valid; the cpu stalls PC update while BUSY_WAIT=1.
// PARAMETERS
//  NUM_BLOCKS   8   cache lines (power of 2); index width IDX_W = log2(NUM_BLOCKS)
//  ADDR_W      10   byte-address width used from PC; tag width = ADDR_W-4-IDX_W (3 at defaults)
// PORTS
//  CLK           in   1        clock; all state updates on posedge
//  RESET         in   1        asynchronous, active-low reset
//  ADDRESS       in   ADDR_W   byte address of instruction (PC[ADDR_W-1:0]); bits [1:0] ignored
//  READ          in   1        fetch request; held high by cpu every cycle it needs an instruction
//  INSTRUCTION   out  32       instruction word at ADDRESS
//  BUSY_WAIT     out  1        1 = INSTRUCTION not yet valid, cpu must stall
//  MEM_READ      out  1        block read request to instruction memory
//  MEM_ADDRESS   out  ADDR_W-4 block address {tag,index}
//  MEM_READDATA  in   128      block from memory; word0 = bits[31:0] ... word3 = bits[127:96]
//  MEM_BUSYWAIT  in   1        memory busy; data valid in the cycle it drops to 0 with MEM_READ high
// BEHAVIOUR
//  - Address split: offset=ADDRESS[3:2] (word), index=ADDRESS[3+IDX_W:4], tag=upper bits.
//  - Storage per line: valid bit, tag, 128-bit data. No dirty bit (read-only cache).
//  - Reset (RESET=0, asynchronous): all valid bits=0, state=IDLE, MEM_READ=0, BUSY_WAIT=0.
//    INSTRUCTION=32'h0 while RESET is asserted. Data/tag arrays are not cleared.
//  - HIT = READ & valid[index] & (tag[index]==tag), evaluated combinationally.
//  - FSM states IDLE, MEM_FETCH, UPDATE:
//    IDLE:
//      - HIT -> INSTRUCTION = selected word, BUSY_WAIT=0, stay IDLE (zero-cycle hit latency).
//      - READ & !HIT -> BUSY_WAIT=1 combinationally, next state MEM_FETCH.
//      - !READ -> BUSY_WAIT=0, INSTRUCTION holds its last value.
//    MEM_FETCH:
//      - MEM_READ=1, MEM_ADDRESS={tag,index}, BUSY_WAIT=1.
//      - Leave to UPDATE on the first posedge with MEM_BUSYWAIT=0.
//    UPDATE:
//      - MEM_READ=0, BUSY_WAIT=1.
//      - On posedge: data[index]<=MEM_READDATA, tag[index]<=tag, valid[index]<=1; next state IDLE.
//      - The following IDLE cycle hits and drops BUSY_WAIT.
//  - Miss penalty = memory latency + 2 cycles (MEM_FETCH exit + UPDATE).
//  - ADDRESS must be stable while BUSY_WAIT=1; the cache latches the tag/index of the miss
//    at IDLE->MEM_FETCH and uses the latched values through UPDATE.
//  - A conflicting line is overwritten unconditionally (no writeback).
//  - READ falling during MEM_FETCH/UPDATE does not abort the fill; the line is still written.
//  - RESET asserted mid-fill:
//    - abort immediately: MEM_READ=0, state=IDLE, all lines invalid;
//    - the block is not written.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    - adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both 0 on reset;
//    - HIT_COUNT +1 on each posedge in IDLE with HIT;
//    - MISS_COUNT +1 on each IDLE->MEM_FETCH transition;
//    - both saturate at 16'hFFFF.
//  ICACHE_STATS_EN undefined: ports and counters absent; the rest of the behaviour is identical.
// TESTING
//  1 Reset: RESET=0 then 1, READ=1, ADDRESS=0 -> BUSY_WAIT=1 same cycle; MEM_READ=1, MEM_ADDRESS=0 next cycle.
//  2 Miss fill: memory returns 128'h...0C_..08_..04_..00 after 5 cycles ->
//    - BUSY_WAIT drops 2 cycles after MEM_BUSYWAIT falls;
//    - INSTRUCTION=word0;
//    - MISS_COUNT=1 (stats enabled).
//  3 Hits: ADDRESS=4,8,12 after test 2 -> BUSY_WAIT=0 every cycle, INSTRUCTION=words 1,2,3, no MEM_READ.
//  4 Conflict: ADDRESS=10'h080 (same index 0, tag 1) -> miss, refill, MEM_ADDRESS=6'h08;
//    then ADDRESS=0 misses again.
//  5 Reset mid-fill: RESET=0 during MEM_FETCH ->
//    - MEM_READ=0 asynchronously;
//    - after release, ADDRESS=0 misses (line invalid).
//  6 READ=0 in IDLE on a cold cache -> no MEM_READ, BUSY_WAIT=0, state stays IDLE.

Source files
------------

// File: rtl/instr_cache_if.sv
// instr_cache_if: bus bundle around the instruction cache.
//   CPU side    : address, read (to cache); instruction, busy_wait (from cache)
//   Memory side : mem_read, mem_address (from cache); mem_readdata, mem_busywait (to cache)
// Modports:
//   slave  - the cache itself
//   master - the environment (CPU fetch stage plus instruction memory)
interface instr_cache_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [31:0]       instruction;
  logic              busy_wait;
  logic              mem_read;
  logic [ADDR_W-5:0] mem_address;
  logic [127:0]      mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  address, read, mem_readdata, mem_busywait,
    output instruction, busy_wait, mem_read, mem_address
  );

  modport master (
    output address, read, mem_readdata, mem_busywait,
    input  instruction, busy_wait, mem_read, mem_address
  );
endinterface

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache between the CPU PC
// and a block-oriented instruction memory (16-byte lines, 4 words per line).
// Hits return the word in the same cycle; a miss stalls the CPU through
// MEM_FETCH and UPDATE, then the following IDLE cycle hits.
// Ports:
//   clk        - clock, all state changes on posedge
//   rst_n      - asynchronous active-low reset
//   bus        - instr_cache_if.slave (CPU request/response + memory block read)
//   hit_count  - saturating hit counter   (only with ICACHE_STATS_EN)
//   miss_count - saturating miss counter  (only with ICACHE_STATS_EN)
// Build option: define ICACHE_STATS_EN to add the hit/miss statistics counters.
module instr_cache #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_cache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`else
  // statistics ports are not present in this build
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_FETCH, UPDATE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;        // index of the miss being filled
  logic [TAG_W-1:0] tag_q;        // tag of the miss being filled
  logic             mem_read_q;
  logic [31:0]      instr_q;      // last instruction delivered on a hit

  // NOTE: line storage is deliberately not reset; the valid bits alone decide
  // whether a line can hit, so the data/tag arrays map onto plain RAM.
  logic [3:0][31:0] data_mem [NUM_BLOCKS];
  logic [TAG_W-1:0] tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;

  logic [1:0]       addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic [31:0]      hit_word;
  logic             fill_done;
  logic             unused_byte_sel;

  assign addr_off        = bus.address[3:2];
  assign addr_idx        = bus.address[4 +: IDX_W];
  assign addr_tag        = bus.address[ADDR_W-1 -: TAG_W];
  assign unused_byte_sel = ^bus.address[1:0];   // fetches are word aligned

  assign hit       = bus.read && valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign hit_word  = data_mem[addr_idx][addr_off];
  assign fill_done = (state == MEM_FETCH) && !bus.mem_busywait;

  // Hits bypass the register so the CPU sees the word with zero latency;
  // otherwise the last delivered word is held (0 after reset).
  assign bus.instruction = hit ? hit_word : instr_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = {tag_q, idx_q};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.busy_wait = 1'b1;
    if (state == IDLE) bus.busy_wait = bus.read && !hit;
    if (!rst_n)        bus.busy_wait = 1'b0;
  end

  // The block is captured on the edge that ends MEM_FETCH, the one cycle the
  // memory guarantees mem_readdata. The line only becomes visible when its
  // valid bit is set in UPDATE, so a reset during UPDATE still leaves it unused.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx_q] <= bus.mem_readdata;
      tag_mem[idx_q]  <= tag_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx_q      <= '0;
      tag_q      <= '0;
      mem_read_q <= 1'b0;
      instr_q    <= '0;
      valid      <= '0;
`ifdef ICACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            instr_q <= hit_word;
`ifdef ICACHE_STATS_EN
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
          end else if (bus.read) begin
            state      <= MEM_FETCH;
            mem_read_q <= 1'b1;
            idx_q      <= addr_idx;
            tag_q      <= addr_tag;
`ifdef ICACHE_STATS_EN
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
          end
        end
        MEM_FETCH: begin
          if (!bus.mem_busywait) begin
            state        <= UPDATE;
            mem_read_q   <= 1'b0;
            valid[idx_q] <= 1'b0;   // old contents of this line are being replaced
          end
        end
        UPDATE: begin
          state        <= IDLE;
          valid[idx_q] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: self-checking bench for instr_cache.
// The driver issues fetches and pushes the expected word and expected stall
// length onto a scoreboard; a monitor pops and compares whenever the cache
// presents a ready instruction. A behavioural memory answers block reads with
// a latency chosen by the driver and checks the requested block address.
module tb_instr_cache;
  localparam int ADDR_W     = 10;
  localparam int NUM_BLOCKS = 8;

  typedef struct {
    int          addr;
    logic [31:0] instr;
    int          stall;
  } exp_t;

  typedef struct {
    int baddr;
    int lat;
  } mem_req_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_cache_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  instr_cache #(.NUM_BLOCKS(NUM_BLOCKS), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int          checks     = 0;
  int          errors     = 0;
  exp_t        sb_q[$];
  mem_req_t    mem_q[$];
  logic [31:0] imem [256];
  bit          model_valid [NUM_BLOCKS];
  int          model_tag   [NUM_BLOCKS];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [127:0] block_data(input logic [5:0] b);
    return {imem[{b, 2'd3}], imem[{b, 2'd2}], imem[{b, 2'd1}], imem[{b, 2'd0}]};
  endfunction

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"},  32'(hit_count),  32'(exp_hits));
    check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_misses));
`endif
  endtask

  function automatic bit model_hit(input int addr);
    int idx = (addr / 16) % NUM_BLOCKS;
    return model_valid[idx] && (model_tag[idx] == addr / (16 * NUM_BLOCKS));
  endfunction

  function automatic void model_install(input int addr);
    model_valid[(addr / 16) % NUM_BLOCKS] = 1'b1;
    model_tag[(addr / 16) % NUM_BLOCKS]   = addr / (16 * NUM_BLOCKS);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_BLOCKS; i++) model_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Drive a fetch and record what the cache must answer and how long it stalls.
  task automatic start_fetch(input int addr, input int force_lat = -1);
    int stall = 0;
    int lat;
    if (!model_hit(addr)) begin
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
      mem_q.push_back('{addr / 16, lat});
      stall = lat + 3;   // miss cycle + (lat+1) MEM_FETCH cycles + UPDATE
      model_install(addr);
      exp_misses++;
    end
    exp_hits++;          // the cycle that finally delivers the word is a hit
    sb_q.push_back('{addr, imem[addr / 4], stall});
    bus.address = 10'(addr);
    bus.read    = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("fetch_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    #1;
  endtask

  task automatic fetch(input int addr, input int force_lat = -1);
    start_fetch(addr, force_lat);
    wait_done();
  endtask

  task automatic idle(input int n);
    bus.read = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every cycle the cache presents a ready instruction.
  initial begin : monitor
    int          stall = 0;
    logic [31:0] last  = 32'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        last  = 32'h0;
      end else if (!bus.read) begin
        stall = 0;
        check("instr_hold", bus.instruction, last);
      end else if (bus.busy_wait) begin
        stall++;
      end else if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("instr@%h", e.addr), bus.instruction, e.instr);
        check($sformatf("stall@%h", e.addr), 32'(stall), 32'(e.stall));
        last  = bus.instruction;
        stall = 0;
      end
    end
  end

  // Behavioural instruction memory.
  initial begin : mem_model
    bit       active    = 1'b0;
    int       remaining = 0;
    mem_req_t r;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.mem_read) begin
        active           = 1'b0;
        bus.mem_busywait = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          if (mem_q.size() == 0) begin
            check("unexpected_mem_read", 32'd1, 32'd0);
            remaining = 0;
          end else begin
            r = mem_q.pop_front();
            check("mem_address", 32'(bus.mem_address), 32'(r.baddr));
            remaining = r.lat;
          end
        end
        if (remaining == 0) begin
          bus.mem_busywait = 1'b0;
          bus.mem_readdata = block_data(bus.mem_address);
        end else begin
          bus.mem_busywait = 1'b1;
          bus.mem_readdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          remaining--;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int a;
    for (int i = 0; i < 256; i++) imem[i] = $urandom();
    for (int i = 0; i < 4; i++)   imem[i] = 32'h1000_0000 + 32'(i * 4);
    model_reset();
    bus.address = '0;
    bus.read    = 1'b0;

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_wait",   32'(bus.busy_wait),   32'd0);
    check("rst_mem_read",    32'(bus.mem_read),    32'd0);
    check("rst_instruction", bus.instruction,      32'h0);
    check_stats("rst");
    rst_n = 1'b1;

    // Cold cache, no request: nothing happens.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy_wait", 32'(bus.busy_wait), 32'd0);
      check("idle_mem_read",  32'(bus.mem_read),  32'd0);
    end

    // First fetch after reset misses; block request follows one cycle later.
    start_fetch(0, 5);
    #1;
    check("miss_busy_same_cycle", 32'(bus.busy_wait), 32'd1);
    check("miss_no_mem_read_yet", 32'(bus.mem_read),  32'd0);
    @(posedge clk);
    #1;
    check("miss_mem_read",    32'(bus.mem_read),    32'd1);
    check("miss_mem_address", 32'(bus.mem_address), 32'd0);
    wait_done();
    check_stats("after_first_miss");

    // Remaining words of the same line hit with no stall.
    fetch(4);
    fetch(8);
    fetch(12);
    check_stats("after_hits");

    // Conflicting tag on index 0 evicts the line, then address 0 misses again.
    fetch(10'h080);
    fetch(10'h084);
    fetch(0);
    check_stats("after_conflict");

    // READ dropped mid-fill: the fill still completes and installs the line.
    bus.address = 10'h254;
    bus.read    = 1'b1;
    mem_q.push_back('{10'h254 / 16, 3});
    model_install(10'h254);
    exp_misses++;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("drop_mem_read",  32'(bus.mem_read),  32'd0);
    check("drop_busy_wait", 32'(bus.busy_wait), 32'd0);
    fetch(10'h258);

    // Reset during MEM_FETCH aborts the fill and invalidates every line.
    bus.address = 10'h1C4;
    bus.read    = 1'b1;
    mem_q.push_back('{10'h1C4 / 16, 4});
    @(posedge clk);
    #1;
    check("midfill_mem_read", 32'(bus.mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_read",    32'(bus.mem_read),    32'd0);
    check("async_rst_busy_wait",   32'(bus.busy_wait),   32'd0);
    check("async_rst_instruction", bus.instruction,      32'h0);
    bus.read = 1'b0;
    mem_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_stats("after_midfill_rst");
    fetch(0);
    fetch(10'h1C4);
    fetch(4);

    // Randomized traffic concentrated on a few tags to force hits and evictions.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
      a = int'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
               ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      fetch(a);
    end
    idle(3);
    check_stats("final");
    check("final_sb_empty",  32'(sb_q.size()),  32'd0);
    check("final_mem_empty", 32'(mem_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
